// File: rtl/spi_byte_stream_ctrl.sv
// Byte-stream feeder for spi_master_mode0: TX FIFO -> one SPI transaction per byte -> RX FIFO.
// Launches only when the RX FIFO has room, so the SPI side can never overflow it.
module spi_byte_stream_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              tx_wr_en,
  input  logic [7:0]        tx_wr_data,
  output logic              tx_full,
  output logic [ADDR_W:0]   tx_level,
  input  logic              rx_rd_en,
  output logic [7:0]        rx_rd_data,
  output logic              rx_empty,
  output logic [ADDR_W:0]   rx_level,
  output logic              spi_start,
  output logic [7:0]        spi_tx_data,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [7:0]        spi_rx_data,
  output logic              active,
  output logic [15:0]       xfer_count,
  output logic              err_tx_ovf,
  output logic              err_rx_udf,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  typedef enum logic {IDLE = 1'b0, WAIT_DONE = 1'b1} state_t;

  state_t state, state_nxt;

  logic [7:0]        tx_mem [DEPTH];
  logic [7:0]        rx_mem [DEPTH];
  logic [ADDR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [ADDR_W:0]   tx_count, rx_count;

  logic tx_empty;
  logic can_launch;
  logic launch;
  logic rx_push;
  logic tx_push;
  logic rx_pop;
  logic unused_busy;

  // The master's busy line carries no information this controller needs.
  assign unused_busy = spi_busy;

  assign tx_full    = (tx_count == FULL_LVL);
  assign tx_empty   = (tx_count == '0);
  assign rx_empty   = (rx_count == '0);
  assign tx_level   = tx_count;
  assign rx_level   = rx_count;
  assign rx_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
  assign active     = (state == WAIT_DONE);

  assign tx_push    = tx_wr_en && !tx_full;
  assign rx_pop     = rx_rd_en && !rx_empty;
  assign can_launch = enable && !tx_empty && (rx_count < FULL_LVL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // done is masked while start is still high so a stale done from the master is never taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (can_launch)             state_nxt = WAIT_DONE;
      WAIT_DONE: if (spi_done && !spi_start) state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    launch  = 1'b0;
    rx_push = 1'b0;
    case (state)
      IDLE:      launch  = can_launch;
      WAIT_DONE: rx_push = spi_done && !spi_start;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_wr_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= spi_rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      spi_start   <= 1'b0;
      spi_tx_data <= 8'h00;
      xfer_count  <= 16'h0000;
      err_tx_ovf  <= 1'b0;
      err_rx_udf  <= 1'b0;
    end else begin
      spi_start <= launch;
      if (launch) begin
        spi_tx_data <= tx_mem[tx_rd_ptr];
        tx_rd_ptr   <= tx_rd_ptr + PTR_ONE;
      end
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      case ({tx_push, launch})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: ;
      endcase

      if (rx_push) begin
        rx_wr_ptr  <= rx_wr_ptr + PTR_ONE;
        xfer_count <= xfer_count + 16'd1;
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: ;
      endcase

      // An error event in the same cycle as err_clr leaves the flag set.
      if (tx_wr_en && tx_full)       err_tx_ovf <= 1'b1;
      else if (err_clr)              err_tx_ovf <= 1'b0;
      if (rx_rd_en && rx_empty)      err_rx_udf <= 1'b1;
      else if (err_clr)              err_rx_udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_byte_stream_ctrl.sv
// Directed bench for spi_byte_stream_ctrl with a behavioural SPI master that answers
// 20 cycles after start with the inverted transmit byte.
module tb_spi_byte_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        tx_wr_en;
  logic [7:0]  tx_wr_data;
  logic        tx_full;
  logic [3:0]  tx_level;
  logic        rx_rd_en;
  logic [7:0]  rx_rd_data;
  logic        rx_empty;
  logic [3:0]  rx_level;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        spi_busy;
  logic        spi_done;
  logic [7:0]  spi_rx_data;
  logic        active;
  logic [15:0] xfer_count;
  logic        err_tx_ovf;
  logic        err_rx_udf;
  logic        err_clr;

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_start = 0;
  int base;
  logic [7:0] burst [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};

  spi_byte_stream_ctrl #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_level(tx_level),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rx_data(spi_rx_data), .active(active),
    .xfer_count(xfer_count), .err_tx_ovf(err_tx_ovf), .err_rx_udf(err_rx_udf),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Master model: done pulses 20 cycles after start is seen, rx = tx ^ 0xFF.
  initial begin
    int mcnt = 0;
    spi_done = 1'b0; spi_busy = 1'b0; spi_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (!rst_n) begin
        mcnt = 0; spi_busy = 1'b0;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          spi_done = 1'b1; spi_busy = 1'b0; spi_rx_data = spi_tx_data ^ 8'hFF;
        end
      end else if (spi_start) begin
        mcnt = 20; spi_busy = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (spi_start === 1'b1) n_start++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; tx_wr_en = 1'b0; rx_rd_en = 1'b0; err_clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wr_tx(input logic [7:0] b);
    @(negedge clk);
    tx_wr_en = 1'b1; tx_wr_data = b;
    @(negedge clk);
    tx_wr_en = 1'b0;
  endtask

  task automatic rd_rx(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, 32'(rx_rd_data), 32'(exp));
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cyc, input string tag);
    int ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!active && !spi_start && (tx_level == 4'd0 || rx_level == 4'd8)) begin
        ok = 1; break;
      end
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic wait_not_full(input int max_cyc, input string tag);
    int ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!tx_full) begin ok = 1; break; end
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic wait_start(input int max_cyc, input string tag);
    int ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (spi_start) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (spi_done) begin ok = 1; break; end
    end
    chk(tag, 32'(ok), 1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; tx_wr_en = 1'b0; tx_wr_data = 8'h00;
    rx_rd_en = 1'b0; err_clr = 1'b0;
    tick(3);
    chk("rst_tx_full",  32'(tx_full), 0);
    chk("rst_tx_level", 32'(tx_level), 0);
    chk("rst_rx_empty", 32'(rx_empty), 1);
    chk("rst_rx_level", 32'(rx_level), 0);
    chk("rst_rx_data",  32'(rx_rd_data), 0);
    chk("rst_start",    32'(spi_start), 0);
    chk("rst_tx_data",  32'(spi_tx_data), 0);
    chk("rst_active",   32'(active), 0);
    chk("rst_xfer",     32'(xfer_count), 0);
    chk("rst_ovf",      32'(err_tx_ovf), 0);
    chk("rst_udf",      32'(err_rx_udf), 0);
    rst_n = 1'b1;

    // Single byte with write-to-start latency
    do_reset();
    enable = 1'b1;
    base = n_start;
    @(negedge clk); tx_wr_en = 1'b1; tx_wr_data = 8'hA5;
    @(negedge clk); tx_wr_en = 1'b0;
    chk("single_lvl1",   32'(tx_level), 1);
    chk("single_nostart", 32'(spi_start), 0);
    @(negedge clk);
    chk("single_start",  32'(spi_start), 1);
    chk("single_txd",    32'(spi_tx_data), 'hA5);
    chk("single_active", 32'(active), 1);
    chk("single_lvl0",   32'(tx_level), 0);
    @(negedge clk);
    chk("single_pulse1", 32'(spi_start), 0);
    chk("single_hold",   32'(spi_tx_data), 'hA5);
    wait_quiet(60, "single_quiet");
    chk("single_nstart", 32'(n_start - base), 1);
    chk("single_rxlvl",  32'(rx_level), 1);
    chk("single_xfer",   32'(xfer_count), 1);
    rd_rx("single_rxd", 8'h5A);
    chk("single_empty",  32'(rx_empty), 1);

    // Burst, ordering and one-idle-cycle gap
    do_reset();
    base = n_start;
    for (int i = 0; i < 4; i++) wr_tx(burst[i]);
    chk("burst_lvl",    32'(tx_level), 4);
    chk("burst_hold",   32'(n_start - base), 0);
    @(negedge clk); enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start(60, "burst_start_seen");
      chk("burst_txd",  32'(spi_tx_data), 32'(burst[k]));
      wait_done(60, "burst_done_seen");
      chk("burst_idle", 32'(active), 0);
      if (k < 3) begin
        @(posedge clk); #1;
        chk("burst_gap", 32'(spi_start), 1);
      end
    end
    wait_quiet(60, "burst_quiet");
    chk("burst_nstart", 32'(n_start - base), 4);
    chk("burst_xfer",   32'(xfer_count), 4);
    rd_rx("burst_rx0", 8'hFF);
    rd_rx("burst_rx1", 8'hAA);
    rd_rx("burst_rx2", 8'h55);
    rd_rx("burst_rx3", 8'h00);

    // TX overflow and error clear
    do_reset();
    for (int i = 0; i < 8; i++) wr_tx(8'(16 + i));
    chk("ovf_full8",  32'(tx_full), 1);
    chk("ovf_noerr",  32'(err_tx_ovf), 0);
    wr_tx(8'hEE);
    chk("ovf_lvl",    32'(tx_level), 8);
    chk("ovf_full",   32'(tx_full), 1);
    chk("ovf_err",    32'(err_tx_ovf), 1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("ovf_clr",    32'(err_tx_ovf), 0);
    enable = 1'b1;
    wait_quiet(400, "ovf_quiet");
    chk("ovf_xfer",   32'(xfer_count), 8);
    chk("ovf_txlvl",  32'(tx_level), 0);
    for (int i = 0; i < 8; i++) rd_rx("ovf_rxd", 8'((16 + i) ^ 255));
    chk("ovf_dropped", 32'(rx_empty), 1);

    // RX backpressure
    do_reset();
    base = n_start;
    for (int i = 0; i < 8; i++) wr_tx(8'(128 + i));
    enable = 1'b1;
    wait_not_full(60, "bp_room1");
    wr_tx(8'h88);
    wait_not_full(60, "bp_room2");
    wr_tx(8'h89);
    wait_quiet(400, "bp_quiet");
    tick(30);
    chk("bp_rxlvl",   32'(rx_level), 8);
    chk("bp_active",  32'(active), 0);
    chk("bp_txlvl",   32'(tx_level), 2);
    chk("bp_nstart",  32'(n_start - base), 8);
    rd_rx("bp_rx0", 8'h7F);
    wait_quiet(60, "bp_quiet2");
    tick(30);
    chk("bp_nstart2", 32'(n_start - base), 9);
    chk("bp_rxlvl2",  32'(rx_level), 8);
    chk("bp_txlvl2",  32'(tx_level), 1);
    chk("bp_xfer",    32'(xfer_count), 9);

    // RX underflow, set wins over clear
    do_reset();
    @(negedge clk); rx_rd_en = 1'b1;
    @(negedge clk); rx_rd_en = 1'b0;
    chk("udf_set",    32'(err_rx_udf), 1);
    chk("udf_lvl",    32'(rx_level), 0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("udf_clr",    32'(err_rx_udf), 0);
    @(negedge clk); rx_rd_en = 1'b1; err_clr = 1'b1;
    @(negedge clk); rx_rd_en = 1'b0; err_clr = 1'b0;
    chk("udf_setwins", 32'(err_rx_udf), 1);

    // Reset during WAIT_DONE
    do_reset();
    enable = 1'b1;
    wr_tx(8'h3C);
    wait_quiet(60, "mid_quiet");
    chk("mid_xfer1",  32'(xfer_count), 1);
    wr_tx(8'hC3);
    tick(5);
    chk("mid_active", 32'(active), 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_act0",   32'(active), 0);
    chk("mid_txd0",   32'(spi_tx_data), 0);
    chk("mid_start0", 32'(spi_start), 0);
    chk("mid_xfer0",  32'(xfer_count), 0);
    chk("mid_rxlvl0", 32'(rx_level), 0);
    chk("mid_rxemp",  32'(rx_empty), 1);
    chk("mid_rxd0",   32'(rx_rd_data), 0);
    chk("mid_txlvl0", 32'(tx_level), 0);
    tick(2);
    rst_n = 1'b1;
    base = n_start;
    tick(40);
    chk("mid_nostart", 32'(n_start - base), 0);
    chk("mid_xfer",   32'(xfer_count), 0);
    chk("mid_idle",   32'(active), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_byte_stream_ctrl.md
# spi_byte_stream_ctrl

Upstream feeder for `spi_master_mode0`. It buffers outgoing bytes in a TX FIFO and launches one master transaction per byte through the master's `start`/`tx_data`/`busy`/`done`/`rx_data` handshake. Each received byte is captured into an RX FIFO, so software or a higher-level engine can stream multi-byte traffic without cycle-accurate control of the master.

## Interface
- `DEPTH`, 8, entries per FIFO; power of two, ≥ 2
- `ADDR_W`, 3, log2(`DEPTH`)
- `clk` input 1 system clock; all logic on rising edge
- `rst_n` input 1 asynchronous, active-low reset
- `enable` input 1 permits launching new transactions
- `tx_wr_en` input 1 push `tx_wr_data` into TX FIFO
- `tx_wr_data` input 8 byte to transmit
- `tx_full` output 1 TX FIFO holds `DEPTH` entries
- `tx_level` output `ADDR_W+1` TX FIFO occupancy
- `rx_rd_en` input 1 pop RX FIFO head
- `rx_rd_data` output 8 RX FIFO head (first-word fall-through)
- `rx_empty` output 1 RX FIFO holds 0 entries
- `rx_level` output `ADDR_W+1` RX FIFO occupancy
- `spi_start` output 1 one-cycle launch pulse to master `start`
- `spi_tx_data` output 8 to master `tx_data`
- `spi_busy` input 1 from master `busy`
- `spi_done` input 1 from master `done`
- `spi_rx_data` input 8 from master `rx_data`
- `active` output 1 FSM not in IDLE
- `xfer_count` output 16 completed bytes; wraps 0xFFFF→0x0000
- `err_tx_ovf` output 1 sticky: write attempted while `tx_full`
- `err_rx_udf` output 1 sticky: read attempted while `rx_empty`
- `err_clr` input 1 clears both sticky errors

## Operation
- **Reset values:**
  - `tx_full`=0, `tx_level`=0, `rx_empty`=1, `rx_level`=0, `rx_rd_data`=0x00.
  - `spi_start`=0, `spi_tx_data`=0x00, `active`=0, `xfer_count`=0.
  - Both error flags are 0; FSM is in IDLE; FIFO pointers are 0.
- **FSM states:** IDLE, WAIT_DONE.
- **IDLE → WAIT_DONE** when `enable` && !TX-empty && `rx_level` < `DEPTH`. On that edge:
  - pop the TX head into `spi_tx_data`;
  - set `spi_start`=1 for exactly one cycle.
- **WAIT_DONE:**
  - `spi_tx_data` is held stable.
  - `spi_done` is ignored during the cycle in which `spi_start` is high.
  - When `spi_done`=1 is sampled: write `spi_rx_data` into the RX FIFO, increment `xfer_count`, return to IDLE.
- `spi_busy` is informational only; it does not gate transitions.
- The RX-space check at launch guarantees the RX FIFO never overflows from the SPI side.
- **`enable` deasserted mid-transfer:** the current byte completes and is stored; no new launch follows.
- **TX write while `tx_full`=1:** the byte is dropped and `err_tx_ovf` is set. This applies even if the FSM pops the TX FIFO on the same edge, because fullness is evaluated before the edge.
- **TX write while not full, simultaneous with an FSM pop:** both take effect; the level is unchanged.
- **RX read while `rx_empty`=1:** ignored; `err_rx_udf` is set.
- **RX read simultaneous with an FSM RX write:** both take effect; the level is unchanged.
- **`err_clr`:** clears both error flags. If an error event occurs in the same cycle as `err_clr`, the flag is set (set wins).
- **Pointer arithmetic:** pointers are `ADDR_W` bits and wrap naturally. Levels are derived from a separate `ADDR_W+1`-bit count.
- **`rst_n` low at any time:** asynchronously returns every register to its reset value and discards FIFO contents and any in-flight byte. The master shares `rst_n`.

## Timing
- TX write at edge E → `tx_level` updates after E. If IDLE and `enable` is set, `spi_start` is high in the cycle after E+1 (2-cycle write-to-start latency).
- `spi_done` sampled at edge D → `rx_level`, `rx_rd_data` (if the FIFO was empty) and `xfer_count` update after D. The FSM is IDLE after D.
- Back-to-back bytes: the next `spi_start` is high in the cycle following D+1. The inter-transaction gap is one idle cycle.
- `active` = 1 exactly while the FSM is in WAIT_DONE.
- All outputs are registered except `tx_full`, `rx_empty` and `rx_rd_data`, which are decoded combinationally from registered state.

## Test plan
- **Single byte:** reset, `enable`=1. Bench master model raises `spi_done` 20 cycles after `spi_start` and returns `spi_rx_data` = `spi_tx_data` ^ 0xFF. Write 0xA5 → exactly one `spi_start` pulse with `spi_tx_data`=0xA5; `rx_rd_data`=0x5A; `rx_level`=1; `xfer_count`=1.
- **Burst and ordering:** write 0x00, 0x55, 0xAA, 0xFF with `enable`=0, then set `enable`=1 → four starts separated by exactly one idle cycle after each `done`. RX pops return 0xFF, 0xAA, 0x55, 0x00; `xfer_count`=4.
- **TX overflow:** `enable`=0, write `DEPTH`+1 bytes → `tx_full`=1, `tx_level`=8, `err_tx_ovf`=1, last byte absent. Pulse `err_clr` → flag returns to 0.
- **RX backpressure:** 10 bytes queued, no RX reads → launches stop with `rx_level`=8 and the FSM in IDLE. One read → exactly one more launch follows.
- **Underflow and set-wins:** read while empty → `err_rx_udf`=1. Read while empty in the same cycle as `err_clr` → flag stays 1.
- **Reset mid-transfer:** assert `rst_n`=0 during WAIT_DONE → all outputs return to reset values immediately. After release, no spurious `spi_start` occurs and `xfer_count`=0.
